trap_controller: RTL

Machine-mode trap controller for the Lagarto Hun core: the parametrised successor of the M-mode CSR block. It holds the trap CSRs, records synchronous exceptions, and arbitrates the standard M-mode interrupts plus `NUM_LOCAL_IRQ` platform interrupts. It sequences trap entry and `mret`, and issues a held PC-redirect handshake to the core front end.

---
 rtl/riscv_privileged_pkg.sv | 65 ++++++
 rtl/trap_interrupt_arbiter.sv | 40 ++++
 rtl/trap_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_privileged_pkg.sv
// Privileged-architecture definitions shared by the M-mode trap controller:
// CSR command encoding, CSR addresses, mstatus field positions, mtvec modes,
// exception/interrupt codes and the trap sequencing state type.
package riscv_privileged_pkg;

    typedef enum logic [1:0] {
        CSR_CMD_NONE           = 2'd0,
        CSR_CMD_READ_ONLY      = 2'd1,
        CSR_CMD_WRITE_ONLY     = 2'd2,
        CSR_CMD_WRITE_AND_READ = 2'd3
    } csr_command_t;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        TRAP_REDIRECT = 2'd1,
        MRET_REDIRECT = 2'd2
    } trap_state_t;

    // Modes 2 and 3 are reserved; writes carrying them leave the mode alone.
    typedef enum logic [1:0] {
        MTVEC_DIRECT     = 2'd0,
        MTVEC_VECTORED   = 2'd1,
        MTVEC_RESERVED_2 = 2'd2,
        MTVEC_RESERVED_3 = 2'd3
    } mtvec_mode_t;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    // Interrupt codes double as bit positions in mip/mie.
    localparam int IRQ_CODE_MSI   = 3;
    localparam int IRQ_CODE_MTI   = 7;
    localparam int IRQ_CODE_MEI   = 11;
    localparam int IRQ_LOCAL_BASE = 16;

    localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
    localparam logic [4:0] EXC_INSTR_ACCESS     = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] EXC_LOAD_ACCESS      = 5'd5;
    localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] EXC_STORE_ACCESS     = 5'd7;
    localparam logic [4:0] EXC_ECALL_M          = 5'd11;

    function automatic logic csr_cmd_reads(input csr_command_t cmd);
        return (cmd == CSR_CMD_READ_ONLY) || (cmd == CSR_CMD_WRITE_AND_READ);
    endfunction

    function automatic logic csr_cmd_writes(input csr_command_t cmd);
        return (cmd == CSR_CMD_WRITE_ONLY) || (cmd == CSR_CMD_WRITE_AND_READ);
    endfunction

endpackage

// File: rtl/trap_interrupt_arbiter.sv
// Fixed-priority encoder over enabled pending interrupts:
// MEI > MSI > MTI > local lines, lowest local index first.
module trap_interrupt_arbiter
    import riscv_privileged_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 16
) (
    input  logic                                            mei_i,
    input  logic                                            msi_i,
    input  logic                                            mti_i,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_i,
    output logic                                            valid_o,
    output logic [5:0]                                      code_o
);

    // Later assignments win, so the loop runs from the lowest priority upward.
    always_comb begin
        valid_o = 1'b0;
        code_o  = '0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (local_i[i]) begin
                valid_o = 1'b1;
                code_o  = 6'(IRQ_LOCAL_BASE + i);
            end
        end
        if (mti_i) begin
            valid_o = 1'b1;
            code_o  = 6'(IRQ_CODE_MTI);
        end
        if (msi_i) begin
            valid_o = 1'b1;
            code_o  = 6'(IRQ_CODE_MSI);
        end
        if (mei_i) begin
            valid_o = 1'b1;
            code_o  = 6'(IRQ_CODE_MEI);
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: trap CSRs, exception capture, interrupt
// arbitration, trap entry / mret sequencing and a held PC-redirect request.
// Optional feature macro: TRAP_VECTORED_EN (writable mtvec.mode, vectored
// interrupt targets). Without it mtvec.mode is hardwired DIRECT.
//
// Redirect handshake: redirect_valid_o rises the cycle after trap entry or
// mret and stays high with redirect_pc_o stable until a cycle in which
// redirect_ready_i is high; the transfer completes on that clock edge and the
// controller returns to IDLE. Ready may already be high when valid rises.
module trap_controller
    import riscv_privileged_pkg::*;
#(
    parameter int               MXLEN         = 64,
    parameter int               NUM_LOCAL_IRQ = 16,
    parameter logic [MXLEN-1:0] BOOT_ADDRESS  = 'h8000_0000
) (
    input  logic                                               clock_i,
    input  logic                                               reset_i,
    input  logic [11:0]                                        csr_address_i,
    input  csr_command_t                                       csr_command_i,
    input  logic [MXLEN-1:0]                                   csr_write_data_i,
    output logic [MXLEN-1:0]                                   csr_read_data_o,
    output logic                                               csr_read_data_valid_o,
    input  logic                                               exception_valid_i,
    input  logic [4:0]                                         exception_cause_i,
    input  logic [MXLEN-1:0]                                   exception_pc_i,
    input  logic [MXLEN-1:0]                                   exception_tval_i,
    input  logic                                               mret_i,
    input  logic                                               next_pc_valid_i,
    input  logic [MXLEN-1:0]                                   next_pc_i,
    input  logic                                               irq_software_i,
    input  logic                                               irq_timer_i,
    input  logic                                               irq_external_i,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_i,
    output logic                                               redirect_valid_o,
    output logic [MXLEN-1:0]                                   redirect_pc_o,
    input  logic                                               redirect_ready_i,
    output logic                                               interrupt_pending_o,
    output trap_state_t                                        trap_state_o
);

    localparam int LOCAL_W = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;

    // Bits of mip/mie that have an interrupt source behind them.
    function automatic logic [MXLEN-1:0] implemented_irq_mask();
        logic [MXLEN-1:0] m;
        m = '0;
        m[IRQ_CODE_MSI] = 1'b1;
        m[IRQ_CODE_MTI] = 1'b1;
        m[IRQ_CODE_MEI] = 1'b1;
        if (NUM_LOCAL_IRQ > 0) begin
            m[IRQ_LOCAL_BASE +: LOCAL_W] = '1;
        end
        return m;
    endfunction

    localparam logic [MXLEN-1:0] IRQ_MASK   = implemented_irq_mask();
    localparam logic [MXLEN-1:0] MISA_VALUE = (MXLEN'(2) << (MXLEN - 2)) | MXLEN'(1 << 8);

    trap_state_t            state_q, state_d;
    logic [MXLEN-1:0]       redirect_pc_q, redirect_pc_d;
    logic                   mstatus_mie_q, mstatus_mie_d;
    logic                   mstatus_mpie_q, mstatus_mpie_d;
    logic [MXLEN-1:0]       mie_q, mie_d;
    logic [MXLEN-1:2]       mtvec_base_q, mtvec_base_d;
    logic [MXLEN-1:0]       mscratch_q, mscratch_d;
    logic [MXLEN-1:0]       mepc_q, mepc_d;
    logic [MXLEN-1:0]       mcause_q, mcause_d;
    logic [MXLEN-1:0]       mtval_q, mtval_d;
    logic                   irq_sw_q, irq_timer_q, irq_ext_q;
    logic [LOCAL_W-1:0]     irq_local_q;
    mtvec_mode_t            mtvec_mode;

    logic [MXLEN-1:0]       mip;
    logic [MXLEN-1:0]       irq_enabled;
    logic [MXLEN-1:0]       mstatus_value;
    logic [MXLEN-1:0]       mepc_aligned;
    logic [MXLEN-1:0]       irq_target;
    logic                   arb_valid;
    logic [5:0]             arb_code;
    logic                   take_irq;
    logic                   csr_write_en;

`ifdef TRAP_VECTORED_EN
    mtvec_mode_t            mtvec_mode_q, mtvec_mode_d;
    assign mtvec_mode = mtvec_mode_q;
`else
    assign mtvec_mode = MTVEC_DIRECT;
`endif

    // Assemble mip from the registered interrupt lines and derived views.
    always_comb begin
        mip = '0;
        mip[IRQ_CODE_MSI] = irq_sw_q;
        mip[IRQ_CODE_MTI] = irq_timer_q;
        mip[IRQ_CODE_MEI] = irq_ext_q;
        if (NUM_LOCAL_IRQ > 0) begin
            mip[IRQ_LOCAL_BASE +: LOCAL_W] = irq_local_q;
        end
        irq_enabled = mip & mie_q;
        mstatus_value = '0;
        mstatus_value[MSTATUS_MIE_BIT]                    = mstatus_mie_q;
        mstatus_value[MSTATUS_MPIE_BIT]                   = mstatus_mpie_q;
        mstatus_value[MSTATUS_MPP_LSB +: 2]               = 2'b11;
        mepc_aligned = {mepc_q[MXLEN-1:2], 2'b00};
    end

    trap_interrupt_arbiter #(
        .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
    ) u_arbiter (
        .mei_i   (irq_enabled[IRQ_CODE_MEI]),
        .msi_i   (irq_enabled[IRQ_CODE_MSI]),
        .mti_i   (irq_enabled[IRQ_CODE_MTI]),
        .local_i (irq_enabled[IRQ_LOCAL_BASE +: LOCAL_W]),
        .valid_o (arb_valid),
        .code_o  (arb_code)
    );

    // Combinational CSR read port; unimplemented addresses read as zero.
    always_comb begin
        csr_read_data_o       = '0;
        csr_read_data_valid_o = csr_cmd_reads(csr_command_i);
        case (csr_address_i)
            CSR_MSTATUS:  csr_read_data_o = mstatus_value;
            CSR_MISA:     csr_read_data_o = MISA_VALUE;
            CSR_MIE:      csr_read_data_o = mie_q;
            CSR_MIP:      csr_read_data_o = mip;
            CSR_MTVEC:    csr_read_data_o = {mtvec_base_q, mtvec_mode};
            CSR_MSCRATCH: csr_read_data_o = mscratch_q;
            CSR_MEPC:     csr_read_data_o = mepc_aligned;
            CSR_MCAUSE:   csr_read_data_o = mcause_q;
            CSR_MTVAL:    csr_read_data_o = mtval_q;
            default:      csr_read_data_valid_o = 1'b0;
        endcase
    end

    // Next-state: CSR writes first, then trap/mret updates override them.
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_base_d   = mtvec_base_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef TRAP_VECTORED_EN
        mtvec_mode_d   = mtvec_mode_q;
`endif

        take_irq   = mstatus_mie_q && next_pc_valid_i && arb_valid;
        irq_target = {mtvec_base_q, 2'b00};
        if (mtvec_mode == MTVEC_VECTORED) begin
            irq_target = irq_target + (MXLEN'(arb_code) << 2);
        end

        csr_write_en = (state_q == IDLE) && !exception_valid_i &&
                       csr_cmd_writes(csr_command_i);
        if (csr_write_en) begin
            case (csr_address_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_write_data_i[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_write_data_i[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d = csr_write_data_i & IRQ_MASK;
                CSR_MTVEC: begin
                    mtvec_base_d = csr_write_data_i[MXLEN-1:2];
`ifdef TRAP_VECTORED_EN
                    if (csr_write_data_i[1:0] == MTVEC_DIRECT ||
                        csr_write_data_i[1:0] == MTVEC_VECTORED) begin
                        mtvec_mode_d = mtvec_mode_t'(csr_write_data_i[1:0]);
                    end
`endif
                end
                CSR_MSCRATCH: mscratch_d = csr_write_data_i;
                CSR_MEPC:     mepc_d     = csr_write_data_i;
                CSR_MCAUSE:   mcause_d   = csr_write_data_i;
                CSR_MTVAL:    mtval_d    = csr_write_data_i;
                default:      ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (exception_valid_i) begin
                    mepc_d         = exception_pc_i;
                    mcause_d       = MXLEN'(exception_cause_i);
                    mtval_d        = exception_tval_i;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    redirect_pc_d  = {mtvec_base_q, 2'b00};
                    state_d        = TRAP_REDIRECT;
                end else if (mret_i) begin
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                    redirect_pc_d  = mepc_aligned;
                    state_d        = MRET_REDIRECT;
                end else if (take_irq) begin
                    mepc_d         = next_pc_i;
                    mcause_d       = (MXLEN'(1) << (MXLEN - 1)) | MXLEN'(arb_code);
                    mtval_d        = '0;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    redirect_pc_d  = irq_target;
                    state_d        = TRAP_REDIRECT;
                end
            end
            TRAP_REDIRECT, MRET_REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, CSR and interrupt-synchroniser registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            redirect_pc_q  <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_base_q   <= BOOT_ADDRESS[MXLEN-1:2];
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            irq_sw_q       <= 1'b0;
            irq_timer_q    <= 1'b0;
            irq_ext_q      <= 1'b0;
            irq_local_q    <= '0;
        end else begin
            state_q        <= state_d;
            redirect_pc_q  <= redirect_pc_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_base_q   <= mtvec_base_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            irq_sw_q       <= irq_software_i;
            irq_timer_q    <= irq_timer_i;
            irq_ext_q      <= irq_external_i;
            irq_local_q    <= irq_local_i;
        end
    end

`ifdef TRAP_VECTORED_EN
    // Trap-vector mode register, only present when vectoring is enabled.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mtvec_mode_q <= MTVEC_DIRECT;
        end else begin
            mtvec_mode_q <= mtvec_mode_d;
        end
    end
`endif

    assign redirect_valid_o    = (state_q != IDLE);
    assign redirect_pc_o       = redirect_pc_q;
    assign interrupt_pending_o = |irq_enabled;
    assign trap_state_o        = state_q;

endmodule
